wall_size_divider: RTL and testbench

- Parametrised successor to the per-column wall tracer. Computes wall size = NUMER / i_divisor using a radix-2 restoring divider: one quotient bit per clock, fixed latency.
- Replaces the variable-latency repeated-subtraction scheme. Adds an explicit start/busy/done handshake, a side tag carried alongside the result, saturation, and an exact-division flag.
- Sits between the ray distance stage and the column renderer. One division per screen column.

---
 rtl/wall_size_divider_if.sv | 25 ++
 rtl/wall_size_divider.sv | 130 +++++++++++++
 tb/tb_wall_size_divider.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wall_size_divider_if.sv
// Start/result handshake bundle for wall_size_divider.
// The requester drives i_* through the master modport; the divider owns o_*.
interface wall_size_divider_if #(
   parameter int unsigned DW = 10,
   parameter int unsigned QW = 11
);
   logic          i_start;
   logic [DW-1:0] i_divisor;
   logic          i_side;
   logic          o_busy;
   logic          o_done;
   logic [QW-1:0] o_size;
   logic          o_side;
   logic          o_exact;

   modport master (
      output i_start, i_divisor, i_side,
      input  o_busy, o_done, o_size, o_side, o_exact
   );

   modport slave (
      input  i_start, i_divisor, i_side,
      output o_busy, o_done, o_size, o_side, o_exact
   );
endinterface

// File: rtl/wall_size_divider.sv
// Fixed-latency radix-2 restoring divider: wall size = NUMER / divisor, one quotient bit per clock.
// Optional macro WALL_TRACER_ROUND_EN rounds to nearest instead of truncating.
module wall_size_divider #(
   parameter int unsigned DW       = 10,
   parameter int unsigned QW       = 11,
   parameter int unsigned NUMER    = 1000,
   parameter int unsigned SIZE_MAX = (2 ** QW) - 1
) (
   input  logic                clk,
   input  logic                reset,
   wall_size_divider_if.slave  bus
);

   localparam int unsigned KW = (QW > 1) ? $clog2(QW) : 1;
   localparam logic [QW-1:0] NUMER_V = QW'(NUMER);

   typedef enum logic {IDLE, DIV} state_t;

   state_t        state_q, state_d;
   logic [DW:0]   rem_q, rem_d;
   logic [QW-1:0] q_q, q_d;
   logic [KW-1:0] k_q, k_d;
   logic [DW-1:0] div_q, div_d;
   logic          side_q, side_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [QW-1:0] size_q, size_d;
   logic          oside_q, oside_d;
   logic          exact_q, exact_d;

   logic [DW+1:0] rem_sh;
   logic          ge;
   logic [DW:0]   rem_nx;
   logic [QW-1:0] q_nx;
   logic [QW:0]   q_ext;
`ifdef WALL_TRACER_ROUND_EN
   logic          rnd;
`endif

   // One restoring step; rem_sh is one bit wider so the shifted-in value never truncates.
   always_comb begin
      rem_sh = {rem_q, NUMER_V[k_q]};
      ge     = (rem_sh >= {2'b00, div_q});
      rem_nx = ge ? (DW+1)'(rem_sh - {2'b00, div_q}) : (DW+1)'(rem_sh);
      q_nx       = q_q;
      q_nx[k_q]  = ge;
   end

   // Final quotient adjustment and saturation; divisor 0 already yields all ones.
   always_comb begin
`ifdef WALL_TRACER_ROUND_EN
      rnd   = ({rem_nx, 1'b0} >= {2'b00, div_q}) && (div_q != '0);
      q_ext = {1'b0, q_nx} + (QW+1)'(rnd);
`else
      q_ext = {1'b0, q_nx};
`endif
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      q_d     = q_q;
      k_d     = k_q;
      div_d   = div_q;
      side_d  = side_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      size_d  = size_q;
      oside_d = oside_q;
      exact_d = exact_q;

      // A start is taken in either state; in DIV it abandons the running division.
      if (bus.i_start) begin
         state_d = DIV;
         div_d   = bus.i_divisor;
         side_d  = bus.i_side;
         rem_d   = '0;
         q_d     = '0;
         k_d     = KW'(QW - 1);
      end else if (state_q == DIV) begin
         rem_d = rem_nx;
         q_d   = q_nx;
         if (k_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            size_d  = (q_ext > (QW+1)'(SIZE_MAX)) ? QW'(SIZE_MAX) : q_ext[QW-1:0];
            oside_d = side_q;
            exact_d = (rem_nx == '0) && (div_q != '0);
         end else begin
            k_d    = k_q - KW'(1);
            busy_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         q_q     <= '0;
         k_q     <= '0;
         div_q   <= '0;
         side_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         size_q  <= '0;
         oside_q <= 1'b0;
         exact_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         k_q     <= k_d;
         div_q   <= div_d;
         side_q  <= side_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         size_q  <= size_d;
         oside_q <= oside_d;
         exact_q <= exact_d;
      end
   end

   assign bus.o_busy  = busy_q;
   assign bus.o_done  = done_q;
   assign bus.o_size  = size_q;
   assign bus.o_side  = oside_q;
   assign bus.o_exact = exact_q;

endmodule

// File: tb/tb_wall_size_divider.sv
// Directed and streaming bench for wall_size_divider with a result scoreboard.
// A second instance with SIZE_MAX=480 exercises saturation.
module tb_wall_size_divider;

   localparam int unsigned DW    = 10;
   localparam int unsigned QW    = 11;
   localparam int unsigned NUMER = 1000;
   localparam int unsigned LAT   = 11;

   typedef struct {
      logic [QW-1:0] size;
      logic          side;
      logic          exact;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t sb[$];
   exp_t last_exp;

   wall_size_divider_if #(.DW(DW), .QW(QW)) bus ();
   wall_size_divider_if #(.DW(DW), .QW(QW)) bus2 ();

   wall_size_divider #(.DW(DW), .QW(QW), .NUMER(NUMER)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   wall_size_divider #(.DW(DW), .QW(QW), .NUMER(NUMER), .SIZE_MAX(480)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input int d, input bit s, input int smax);
      exp_t e;
      int   q;
      int   r;
      if (d == 0) begin
         q = (2 ** QW) - 1;
         r = 1;
      end else begin
         q = NUMER / d;
         r = NUMER % d;
      end
`ifdef WALL_TRACER_ROUND_EN
      if (d != 0 && 2 * r >= d) q = q + 1;
`endif
      if (q > smax) q = smax;
      e.size  = QW'(q);
      e.side  = s;
      e.exact = (d != 0) && (r == 0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the next posedge is the accept edge.
   task automatic issue(input int d, input bit s, input bit push);
      bus.i_start   = 1'b1;
      bus.i_divisor = DW'(d);
      bus.i_side    = s;
      if (push) sb.push_back(model(d, s, (2 ** QW) - 1));
   endtask

   // Returns at the negedge of the expected o_done cycle.
   task automatic await_done(input string tag);
      bit   early;
      bit   busy_bad;
      exp_t e;
      early    = 1'b0;
      busy_bad = 1'b0;
      @(negedge clk);
      bus.i_start = 1'b0;
      for (int n = 1; n <= LAT; n++) begin
         @(negedge clk);
         if (n < LAT) begin
            if (bus.o_done !== 1'b0) early = 1'b1;
            if (bus.o_busy !== 1'b1) busy_bad = 1'b1;
         end
      end
      chk({tag, "_no_early_done"}, 32'(early), 32'd0);
      chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
      chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
      chk({tag, "_busy_low_at_done"}, 32'(bus.o_busy), 32'd0);
      if (sb.size() == 0) begin
         chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_size"}, 32'(bus.o_size), 32'(e.size));
         chk({tag, "_side"}, 32'(bus.o_side), 32'(e.side));
         chk({tag, "_exact"}, 32'(bus.o_exact), 32'(e.exact));
         last_exp = e;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
      chk({tag, "_size"}, 32'(bus.o_size), 32'd0);
      chk({tag, "_side"}, 32'(bus.o_side), 32'd0);
      chk({tag, "_exact"}, 32'(bus.o_exact), 32'd0);
   endtask

   initial begin
      exp_t e;
      bit   stray;
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      bus.i_start   = 1'b0;
      bus.i_divisor = '0;
      bus.i_side    = 1'b0;
      bus2.i_start  = 1'b0;
      bus2.i_divisor = '0;
      bus2.i_side   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_zero("reset");

      // Directed single operations.
      issue(4, 1'b1, 1'b1);  await_done("div4");
      chk("div4_size_const", 32'(bus.o_size), 32'd250);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.o_done), 32'd0);
      chk("size_held", 32'(bus.o_size), 32'd250);
      issue(3, 1'b0, 1'b1);  await_done("div3");
      chk("div3_size_const", 32'(bus.o_size), 32'd333);
      issue(6, 1'b1, 1'b1);  await_done("div6");
      issue(1, 1'b0, 1'b1);  await_done("div1");
      chk("div1_size_const", 32'(bus.o_size), 32'd1000);
      issue(0, 1'b1, 1'b1);  await_done("div0");
      chk("div0_size_const", 32'(bus.o_size), 32'd2047);
      issue(1023, 1'b0, 1'b1); await_done("div1023");

      // Back-to-back: start asserted in the done cycle.
      issue(5, 1'b1, 1'b1);  await_done("b2b");
      chk("b2b_size_const", 32'(bus.o_size), 32'd200);

      // Restart while busy: first operation abandoned silently.
      @(negedge clk);
      issue(4, 1'b1, 1'b0);
      @(negedge clk);
      bus.i_start = 1'b0;
      stray = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.o_done !== 1'b0 || bus.o_size !== last_exp.size ||
             bus.o_side !== last_exp.side || bus.o_exact !== last_exp.exact) stray = 1'b1;
      end
      chk("restart_outputs_held", 32'(stray), 32'd0);
      issue(8, 1'b0, 1'b1);  await_done("restart");
      chk("restart_size_const", 32'(bus.o_size), 32'd125);

      // Reset in the middle of an operation.
      @(negedge clk);
      issue(7, 1'b1, 1'b0);
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_zero("midreset");
      stray = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (bus.o_done !== 1'b0) stray = 1'b1;
      end
      chk("midreset_no_done", 32'(stray), 32'd0);
      issue(4, 1'b1, 1'b1);  await_done("post_reset");

      // Saturation instance.
      bus2.i_start   = 1'b1;
      bus2.i_divisor = DW'(1);
      bus2.i_side    = 1'b1;
      @(negedge clk);
      bus2.i_start = 1'b0;
      repeat (LAT) @(negedge clk);
      e = model(1, 1'b1, 480);
      chk("sat_done", 32'(bus2.o_done), 32'd1);
      chk("sat_size", 32'(bus2.o_size), 32'(e.size));
      chk("sat_size_const", 32'(bus2.o_size), 32'd480);

      // Continuous streaming of random divisors.
      for (int i = 0; i < 1000; i++) begin
         int d;
         d = (i % 4 == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 1023));
         issue(d, 1'(($urandom() >> 3) & 1), 1'b1);
         await_done("stream");
      end
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
